// File: rtl/iss_pkg.sv
// Shared defaults and the issue-queue entry layout for the ISS stage.
package iss_pkg;

  localparam int ISS_TAG_W    = 6;
  localparam int ISS_PAY_W    = 44;
  localparam int ISS_NUM_WAKE = 3;
  localparam int ISS_DEPTH    = 16;

  typedef struct packed {
    logic                 valid;
    logic [ISS_PAY_W-1:0] pay;
    logic [ISS_TAG_W-1:0] src1;
    logic                 rdy1;
    logic [ISS_TAG_W-1:0] src2;
    logic                 rdy2;
    logic [ISS_TAG_W-1:0] dst;
    logic                 dstv;
  } iss_entry_t;

  function automatic int iss_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/iss_age_select.sv
// Oldest-first priority encoder: slot 0 is oldest, so the lowest set request wins.
module iss_age_select
  import iss_pkg::*;
#(
  parameter int DEPTH = ISS_DEPTH,
  parameter int IDX_W = iss_idx_w(DEPTH)
) (
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iss_issue_queue.sv
// Collapsing out-of-order issue queue with wakeup, flush, FREEZE stall and occupancy count.
// Optional busy-bit table for source readiness: define ISS_BUSY_TABLE_EN.
module iss_issue_queue
  import iss_pkg::*;
#(
  parameter int DEPTH    = ISS_DEPTH,
  parameter int TAG_W    = ISS_TAG_W,
  parameter int PAY_W    = ISS_PAY_W,
  parameter int NUM_WAKE = ISS_NUM_WAKE,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      FREEZE,
  input  logic                      flush_IN,
  input  logic                      disp_valid_IN,
  output logic                      disp_ready_OUT,
  input  logic [PAY_W-1:0]          disp_pay_IN,
  input  logic [TAG_W-1:0]          disp_src1_IN,
  input  logic [TAG_W-1:0]          disp_src2_IN,
  input  logic [1:0]                disp_rdy_IN,
  input  logic [TAG_W-1:0]          disp_dst_IN,
  input  logic                      disp_dstv_IN,
  input  logic [NUM_WAKE-1:0]       wake_valid_IN,
  input  logic [NUM_WAKE*TAG_W-1:0] wake_tag_IN,
  output logic                      iss_valid_OUT,
  output logic [PAY_W-1:0]          iss_pay_OUT,
  output logic [TAG_W-1:0]          iss_dst_OUT,
  output logic                      iss_dstv_OUT,
  output logic [CNT_W-1:0]          count_OUT,
  output logic                      empty_OUT
);

  localparam int IDX_W = iss_idx_w(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [PAY_W-1:0] pay;
    logic [TAG_W-1:0] src1;
    logic             rdy1;
    logic [TAG_W-1:0] src2;
    logic             rdy2;
    logic [TAG_W-1:0] dst;
    logic             dstv;
  } entry_t;

  function automatic logic f_woken(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_WAKE-1:0]       vld,
    input logic [NUM_WAKE*TAG_W-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_WAKE; i++) begin
      if (vld[i] && (tags[i*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  entry_t           r_q     [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic             r_iss_valid;
  logic [PAY_W-1:0] r_iss_pay;
  logic [TAG_W-1:0] r_iss_dst;
  logic             r_iss_dstv;

  entry_t           w_woke  [DEPTH+1];
  entry_t           w_next  [DEPTH];
  entry_t           w_new;
  logic [DEPTH-1:0] w_req;
  logic [DEPTH-1:0] w_grant;
  logic [DEPTH-1:0] w_mask;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_any;
  logic             w_issue;
  logic             w_accept;
  logic [CNT_W-1:0] w_wr_idx;
  logic [1:0]       w_base_rdy;

  assign disp_ready_OUT = (r_count != CNT_W'(DEPTH));
  assign empty_OUT      = (r_count == '0);
  assign count_OUT      = r_count;
  assign iss_valid_OUT  = r_iss_valid;
  assign iss_pay_OUT    = r_iss_pay;
  assign iss_dst_OUT    = r_iss_dst;
  assign iss_dstv_OUT   = r_iss_dstv;

  assign w_accept = disp_valid_IN & disp_ready_OUT & ~flush_IN;
  assign w_issue  = w_any & ~FREEZE & ~flush_IN;
  // Issuing frees a lower slot, so the new entry lands one below the current top.
  assign w_wr_idx = r_count - CNT_W'(w_issue);

`ifdef ISS_BUSY_TABLE_EN
  logic [(1<<TAG_W)-1:0] r_busy;
  logic                  w_unused_rdy;

  assign w_unused_rdy = ^disp_rdy_IN;
  assign w_base_rdy   = {~r_busy[disp_src2_IN], ~r_busy[disp_src1_IN]};

  // Later NBAs win, so a same-cycle dispatch set overrides a wakeup clear.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_WAKE; i++) begin
        if (wake_valid_IN[i]) r_busy[wake_tag_IN[i*TAG_W +: TAG_W]] <= 1'b0;
      end
      if (w_accept && disp_dstv_IN && (disp_dst_IN != '0)) r_busy[disp_dst_IN] <= 1'b1;
    end
  end
`else
  assign w_base_rdy = disp_rdy_IN;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_req
      assign w_req[gi]  = r_q[gi].valid & r_q[gi].rdy1 & r_q[gi].rdy2;
      assign w_mask[gi] = |w_grant[gi:0];
    end
  endgenerate

  iss_age_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_age_select (
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_idx   (w_sel_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.pay   = disp_pay_IN;
    w_new.src1  = disp_src1_IN;
    w_new.src2  = disp_src2_IN;
    w_new.dst   = disp_dst_IN;
    w_new.dstv  = disp_dstv_IN;
    w_new.rdy1  = w_base_rdy[0] | f_woken(disp_src1_IN, wake_valid_IN, wake_tag_IN);
    w_new.rdy2  = w_base_rdy[1] | f_woken(disp_src2_IN, wake_valid_IN, wake_tag_IN);
  end

  // Extra top slot is an empty entry that shifts into slot DEPTH-1 on issue.
  always_comb begin
    for (int j = 0; j <= DEPTH; j++) w_woke[j] = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_woke[j]      = r_q[j];
      w_woke[j].rdy1 = r_q[j].rdy1 | f_woken(r_q[j].src1, wake_valid_IN, wake_tag_IN);
      w_woke[j].rdy2 = r_q[j].rdy2 | f_woken(r_q[j].src2, wake_valid_IN, wake_tag_IN);
    end
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_next[j] = (w_issue && w_mask[j]) ? w_woke[j+1] : w_woke[j];
      if (w_accept && (w_wr_idx == CNT_W'(j))) w_next[j] = w_new;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int j = 0; j < DEPTH; j++) r_q[j] <= '0;
      r_count     <= '0;
      r_iss_valid <= 1'b0;
      r_iss_pay   <= '0;
      r_iss_dst   <= '0;
      r_iss_dstv  <= 1'b0;
    end else if (flush_IN) begin
      for (int j = 0; j < DEPTH; j++) r_q[j] <= '0;
      r_count     <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      for (int j = 0; j < DEPTH; j++) r_q[j] <= w_next[j];
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
      if (!FREEZE) begin
        r_iss_valid <= w_issue;
        if (w_issue) begin
          r_iss_pay  <= r_q[w_sel_idx].pay;
          r_iss_dst  <= r_q[w_sel_idx].dst;
          r_iss_dstv <= r_q[w_sel_idx].dstv;
        end
      end
    end
  end

endmodule

// File: tb/tb_iss_issue_queue.sv
// Scoreboard bench for iss_issue_queue: age-ordered queue model, issue events checked by a monitor.
module tb_iss_issue_queue;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        FREEZE = 1'b0;
  logic        flush_IN = 1'b0;
  logic        disp_valid_IN = 1'b0;
  logic        disp_ready_OUT;
  logic [43:0] disp_pay_IN = '0;
  logic [5:0]  disp_src1_IN = '0;
  logic [5:0]  disp_src2_IN = '0;
  logic [1:0]  disp_rdy_IN = '0;
  logic [5:0]  disp_dst_IN = '0;
  logic        disp_dstv_IN = 1'b0;
  logic [2:0]  wake_valid_IN = '0;
  logic [17:0] wake_tag_IN = '0;
  logic        iss_valid_OUT;
  logic [43:0] iss_pay_OUT;
  logic [5:0]  iss_dst_OUT;
  logic        iss_dstv_OUT;
  logic [4:0]  count_OUT;
  logic        empty_OUT;

  iss_issue_queue dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .flush_IN(flush_IN),
    .disp_valid_IN(disp_valid_IN), .disp_ready_OUT(disp_ready_OUT),
    .disp_pay_IN(disp_pay_IN), .disp_src1_IN(disp_src1_IN), .disp_src2_IN(disp_src2_IN),
    .disp_rdy_IN(disp_rdy_IN), .disp_dst_IN(disp_dst_IN), .disp_dstv_IN(disp_dstv_IN),
    .wake_valid_IN(wake_valid_IN), .wake_tag_IN(wake_tag_IN),
    .iss_valid_OUT(iss_valid_OUT), .iss_pay_OUT(iss_pay_OUT), .iss_dst_OUT(iss_dst_OUT),
    .iss_dstv_OUT(iss_dstv_OUT), .count_OUT(count_OUT), .empty_OUT(empty_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [43:0] pay;
    logic [5:0]  s1, s2, dst;
    bit          r1, r2, dv;
  } ment_t;
  typedef struct {
    logic [43:0] pay;
    logic [5:0]  dst;
    bit          dv;
  } iss_t;

  ment_t mq[$];
  iss_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    hv = 0;
  logic [43:0] hpay = '0;
  int    sel;
  bit    acc;
  ment_t ne;
  iss_t  ie;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit woke(input logic [5:0] tag);
    for (int i = 0; i < 3; i++)
      if (wake_valid_IN[i] && wake_tag_IN[i*6 +: 6] == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: an age-ordered list, oldest fully-ready entry leaves on each unfrozen edge.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mq.delete();
      exp_q.delete();
      hv = 0;
      hpay = '0;
    end else if (flush_IN) begin
      mq.delete();
      hv = 0;
    end else begin
      acc = disp_valid_IN && (mq.size() < DEPTH);
      sel = -1;
      if (!FREEZE) begin
        for (int i = 0; i < mq.size(); i++)
          if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
        hv = (sel >= 0);
      end
      if (sel >= 0) begin
        ie.pay = mq[sel].pay; ie.dst = mq[sel].dst; ie.dv = mq[sel].dv;
        exp_q.push_back(ie);
        hpay = mq[sel].pay;
        mq.delete(sel);
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (woke(mq[i].s1)) mq[i].r1 = 1;
        if (woke(mq[i].s2)) mq[i].r2 = 1;
      end
      if (acc) begin
        ne.pay = disp_pay_IN; ne.s1 = disp_src1_IN; ne.s2 = disp_src2_IN;
        ne.dst = disp_dst_IN; ne.dv = disp_dstv_IN;
        ne.r1 = disp_rdy_IN[0] || woke(disp_src1_IN);
        ne.r2 = disp_rdy_IN[1] || woke(disp_src2_IN);
        mq.push_back(ne);
      end
    end
  end

  // Monitor: pops one expected issue per issue event, otherwise checks the held/idle output.
  always @(negedge CLK) begin
    if (RESET) begin
      chk("count", 64'(count_OUT), 64'(mq.size()));
      chk("empty", 64'(empty_OUT), 64'(mq.size() == 0));
      chk("disp_ready", 64'(disp_ready_OUT), 64'(mq.size() < DEPTH));
      if (exp_q.size() > 0) begin
        ie = exp_q.pop_front();
        chk("iss_valid", 64'(iss_valid_OUT), 64'd1);
        chk("iss_pay", 64'(iss_pay_OUT), 64'(ie.pay));
        chk("iss_dst", 64'(iss_dst_OUT), 64'(ie.dst));
        chk("iss_dstv", 64'(iss_dstv_OUT), 64'(ie.dv));
        if (exp_q.size() > 0) begin
          chk("extra_issue_pending", 64'(exp_q.size()), 64'd0);
          exp_q.delete();
        end
      end else begin
        chk("iss_valid_idle", 64'(iss_valid_OUT), 64'(hv));
        if (hv) chk("iss_pay_held", 64'(iss_pay_OUT), 64'(hpay));
      end
    end
  end

  task automatic cyc(input bit v, input logic [43:0] p, input logic [5:0] s1, input logic [5:0] s2,
                     input logic [1:0] rdy, input logic [5:0] d, input bit dv,
                     input logic [2:0] wv, input logic [17:0] wt, input bit frz, input bit fl);
    disp_valid_IN = v; disp_pay_IN = p; disp_src1_IN = s1; disp_src2_IN = s2;
    disp_rdy_IN = rdy; disp_dst_IN = d; disp_dstv_IN = dv;
    wake_valid_IN = wv; wake_tag_IN = wt; FREEZE = frz; flush_IN = fl;
    @(negedge CLK);
  endtask

  task automatic idle(input int n, input bit frz);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, '0, 2'b00, '0, 0, '0, '0, frz, 0);
  endtask

  logic [43:0] rp;
  logic [2:0]  rwv;
  logic [17:0] rwt;

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_count", 64'(count_OUT), 64'd0);
    chk("rst_empty", 64'(empty_OUT), 64'd1);
    chk("rst_ready", 64'(disp_ready_OUT), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid_OUT), 64'd0);
    chk("rst_iss_pay", 64'(iss_pay_OUT), 64'd0);
    chk("rst_iss_dst", 64'({iss_dstv_OUT, iss_dst_OUT}), 64'd0);
    RESET = 1'b1;
    @(negedge CLK);

    // Single ready dispatch.
    cyc(1, 44'hA0A, 6'd5, 6'd6, 2'b11, 6'd10, 1, '0, '0, 0, 0);
    idle(3, 0);
    // Younger ready entry overtakes older one waiting on tag 9.
    cyc(1, 44'hA1, 6'd9, 6'd6, 2'b10, 6'd11, 1, '0, '0, 0, 0);
    cyc(1, 44'hB1, 6'd1, 6'd2, 2'b11, 6'd12, 0, '0, '0, 0, 0);
    idle(2, 0);
    cyc(0, '0, '0, '0, 2'b00, '0, 0, 3'b001, 18'd9, 0, 0);
    idle(3, 0);
    // Fill to capacity, extra dispatch dropped, single wakeup drains in age order.
    for (int i = 0; i < DEPTH + 1; i++)
      cyc(1, 44'(32'h100 + i), 6'd20, 6'd20, 2'b00, 6'(i), 1, '0, '0, 0, 0);
    idle(1, 0);
    cyc(0, '0, '0, '0, 2'b00, '0, 0, 3'b010, {6'd0, 6'd20, 6'd0}, 0, 0);
    idle(DEPTH + 2, 0);
    // Dispatch/wakeup bypass on channel 2.
    cyc(1, 44'hC12, 6'd3, 6'd12, 2'b01, 6'd13, 1, 3'b100, {6'd12, 6'd0, 6'd0}, 0, 0);
    idle(3, 0);
    // FREEZE with ready entries, then release.
    cyc(1, 44'hD0, 6'd1, 6'd1, 2'b11, 6'd1, 1, '0, '0, 0, 0);
    cyc(1, 44'hD1, 6'd1, 6'd1, 2'b11, 6'd2, 1, '0, '0, 1, 0);
    cyc(1, 44'hD2, 6'd1, 6'd1, 2'b11, 6'd3, 1, '0, '0, 1, 0);
    idle(3, 1);
    idle(4, 0);
    // Flush with 7 waiting entries and a simultaneous dispatch.
    for (int i = 0; i < 7; i++)
      cyc(1, 44'(32'h700 + i), 6'd30, 6'd31, 2'b00, 6'd4, 1, '0, '0, 0, 0);
    cyc(1, 44'h7FF, 6'd1, 6'd1, 2'b11, 6'd5, 1, '0, '0, 0, 1);
    idle(2, 0);

    // Randomised traffic over a small tag space so wakeups hit often.
    for (int n = 0; n < 1500; n++) begin
      rp = {12'($urandom), $urandom};
      rwv = '0;
      rwt = '0;
      for (int c = 0; c < 3; c++) begin
        rwv[c] = ($urandom_range(0, 2) == 0);
        rwt[c*6 +: 6] = 6'($urandom_range(1, 7));
      end
      cyc($urandom_range(0, 9) < 6, rp, 6'($urandom_range(1, 7)), 6'($urandom_range(1, 7)),
          2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
          rwv, rwt, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end
    idle(3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
